cdb_tx_buffer: RTL
==================

// Module: cdb_tx_buffer
//
// PURPOSE
//  Result buffer between one execution unit (EU) and the common data bus (CDB) arbiter.
//  Accepts cdb_data_t results from the EU pipeline.
//  Queues them in order; presents the oldest to the CDB with a valid/ready handshake.
//  The EU keeps issuing while the arbiter serves other units.
//  One instance per low-priority EU, feeding one rs_valid/rs_ready/rs_data slot of the CDB.
//
// PARAMETERS
//  DEPTH  4  number of result entries; power of two, >= 2
//
// PORTS
//  clk_i        in   1                     clock
//  rst_n_i      in   1                     asynchronous reset, active low
//  flush_i      in   1                     synchronous flush (mispredict/exception)
//  eu_valid_i   in   1                     EU has a result
//  eu_ready_o   out  1                     buffer can accept a result
//  eu_data_i    in   cdb_data_t            EU result (rob_idx, res_value, except_raised, except_code)
//  cdb_valid_o  out  1                     oldest result available to the CDB arbiter
//  cdb_ready_i  in   1                     arbiter grants this unit
//  cdb_data_o   out  cdb_data_t            oldest result
//  count_o      out  $clog2(DEPTH)+1       occupied entries (debug/perf)
//
// BEHAVIOUR
//  - Reset (rst_n_i=0, async) state:
//    - head, tail and count = 0.
//    - eu_ready_o=1, cdb_valid_o=0, count_o=0.
//    - cdb_data_o is don't-care; it is driven from entry[head].
//    - Entry storage is not reset.
//  - Push on eu_valid_i & eu_ready_o:
//    - Write entry[tail], then tail <= tail+1.
//    - tail is $clog2(DEPTH) bits and wraps naturally DEPTH-1 -> 0.
//  - Pop on cdb_valid_o & cdb_ready_i: head <= head+1 with the same wrap.
//  - Ready/valid rules:
//    - eu_ready_o = (count != DEPTH), a function of registered state only.
//    - cdb_valid_o = (count != 0), a function of registered state only.
//    - There is no combinational path from any input to any handshake output.
//  - Latency: a result pushed in cycle N is visible on cdb_valid_o/cdb_data_o in cycle N+1 at the earliest. There is no bypass.
//  - Count update:
//    - push only: count+1.
//    - pop only: count-1.
//    - push & pop in the same cycle: count unchanged, both pointers advance.
//  - Full (count==DEPTH):
//    - eu_ready_o=0, so no push occurs, even if a pop happens in the same cycle.
//    - A pop frees one entry; eu_ready_o=1 in the next cycle.
//  - Empty (count==0): cdb_valid_o=0, and cdb_ready_i is ignored.
//  - Sustained throughput: 1 result/cycle whenever 0<count<DEPTH and both sides handshake.
//  - Ordering: strict FIFO; results leave in acceptance order.
//  - Data stability: while cdb_valid_o=1 and cdb_ready_i=0, cdb_data_o is held stable.
//  - flush_i (synchronous, highest priority):
//    - Next cycle: head=tail=count=0, cdb_valid_o=0, eu_ready_o=1.
//    - A push or pop in the flush cycle is discarded and does not count.
//  - Reset asserted mid-operation: immediate return to the reset state; all queued results are lost.
//  - Exception results (except_raised=1) are queued and forwarded unchanged. The buffer never inspects payload.
//
// STRUCTURE
//  - cdb_data_t and EU_N stay in expipe_pkg; no new package types are needed.
//  - Optional sub-module: fifo_ptr_ctrl, holding the head/tail/count registers and the full/empty logic.
//  - Storage is a DEPTH x cdb_data_t register array, read by head, in this module.
//  - An assertion (simulation only) checks:
//    - DEPTH is a power of two;
//    - no push when full;
//    - no pop when empty.
//
// TESTING
//  1. Reset, then push rob_idx 1, 2, 3 with cdb_ready_i=0.
//     -> cdb_valid_o rises 1 cycle after the first push; count_o=3; cdb_data_o.rob_idx stays 1.
//  2. Fill 4 entries, hold cdb_ready_i=0, assert eu_valid_i.
//     -> eu_ready_o=0 and no overwrite.
//     -> One pop gives eu_ready_o=1 the next cycle; output order is 1, 2, 3, 4, 5.
//  3. count=2 with eu_valid_i=1 and cdb_ready_i=1 held for 10 cycles.
//     -> One result per cycle; count_o stays 2; pointers wrap past 3 -> 0 without loss.
//  4. count=3, then flush_i together with a push and a pop.
//     -> Next cycle: count_o=0, cdb_valid_o=0, eu_ready_o=1; the flushed results never appear later.
//  5. rst_n_i pulsed low asynchronously (off clock edge) with count=2.
//     -> Outputs take reset values immediately; next push of rob_idx 7 is the first result out.
//  6. Push a result with except_raised=1 and except_code=2.
//     -> It is delivered on cdb_data_o bit-exact, in order between its neighbours.

Source files
------------

// File: rtl/expipe_pkg.sv
// Shared execution-pipeline types: the result record carried on the common data bus.
package expipe_pkg;

    localparam int EU_N       = 4;
    localparam int ROB_IDX_W  = 6;
    localparam int XLEN       = 32;
    localparam int EXC_CODE_W = 4;

    typedef struct packed {
        logic [ROB_IDX_W-1:0]  rob_idx;
        logic [XLEN-1:0]       res_value;
        logic                  except_raised;
        logic [EXC_CODE_W-1:0] except_code;
    } cdb_data_t;

endpackage

// File: rtl/cdb_tx_buffer_fifo_ptr_ctrl.sv
// Head/tail/count bookkeeping for the CDB result buffer; handshake flags come
// from registered state only so no input reaches eu_ready/cdb_valid combinationally.
module cdb_tx_buffer_fifo_ptr_ctrl #(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push_req,
    input  logic             pop_req,
    output logic             push,
    output logic             pop,
    output logic [PTR_W-1:0] head,
    output logic [PTR_W-1:0] tail,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);
    assign push  = push_req && !full;
    assign pop   = pop_req && !empty;

    assign head  = head_reg;
    assign tail  = tail_reg;
    assign count = count_reg;

    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush) begin
            // Flush wins over any handshake in the same cycle.
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
        end else begin
            if (push) tail_next = tail_reg + 1'b1;
            if (pop)  head_next = head_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_next = count_reg + 1'b1;
                2'b01:   count_next = count_reg - 1'b1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/cdb_tx_buffer.sv
// In-order result queue between one execution unit and its CDB arbiter slot.
// The oldest entry is always presented; there is no bypass from EU to CDB.
module cdb_tx_buffer
    import expipe_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             eu_valid_i,
    output logic             eu_ready_o,
    input  cdb_data_t        eu_data_i,
    output logic             cdb_valid_o,
    input  logic             cdb_ready_i,
    output cdb_data_t        cdb_data_o,
    output logic [CNT_W-1:0] count_o
);

    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    cdb_data_t entry_mem [DEPTH];

    cdb_tx_buffer_fifo_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .flush    (flush_i),
        .push_req (eu_valid_i),
        .pop_req  (cdb_ready_i),
        .push     (push),
        .pop      (pop),
        .head     (head),
        .tail     (tail),
        .count    (count_o),
        .full     (full),
        .empty    (empty)
    );

    // Payload storage is deliberately left unreset; validity lives in count.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            entry_mem[tail] <= eu_data_i;
        end
    end

    assign eu_ready_o  = !full;
    assign cdb_valid_o = !empty;
    assign cdb_data_o  = entry_mem[head];

    always @(posedge clk_i) begin
        if (rst_n_i) begin
            assert (DEPTH >= 2 && (DEPTH & (DEPTH - 1)) == 0)
                else $error("cdb_tx_buffer: DEPTH %0d is not a power of two >= 2", DEPTH);
            assert (!(push && full))
                else $error("cdb_tx_buffer: push while full");
            assert (!(pop && empty))
                else $error("cdb_tx_buffer: pop while empty");
        end
    end

endmodule
